// File: rtl/fir_secuenciador_mac_pkg.sv
// Shared types and constants for the FIR tap sequencer.
// Coefficient source selected by FIR_COEF_WR_EN (writable file vs. constant table).
`ifndef FIR_ANCHO
`define FIR_ANCHO 16
`endif

package fir_secuenciador_mac_pkg;

    localparam int ANCHO = `FIR_ANCHO;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam logic [ANCHO-1:0] COEF_0  = ANCHO'(16'h1000);
    localparam logic [ANCHO-1:0] COEF_1  = ANCHO'(16'h0800);
    localparam logic [ANCHO-1:0] COEF_2  = ANCHO'(16'h0400);
    localparam logic [ANCHO-1:0] COEF_3  = ANCHO'(16'h0200);
    localparam logic [ANCHO-1:0] COEF_4  = ANCHO'(16'h0100);
    localparam logic [ANCHO-1:0] COEF_5  = ANCHO'(16'h0080);
    localparam logic [ANCHO-1:0] COEF_6  = ANCHO'(16'h0040);
    localparam logic [ANCHO-1:0] COEF_7  = ANCHO'(16'h0020);
    localparam logic [ANCHO-1:0] COEF_8  = ANCHO'(16'h0010);
    localparam logic [ANCHO-1:0] COEF_9  = ANCHO'(16'h0008);
    localparam logic [ANCHO-1:0] COEF_10 = ANCHO'(16'h0004);
    localparam logic [ANCHO-1:0] COEF_11 = ANCHO'(16'h0002);
    localparam logic [ANCHO-1:0] COEF_12 = ANCHO'(16'h0001);
    localparam logic [ANCHO-1:0] COEF_13 = ANCHO'(16'hFFFF);
    localparam logic [ANCHO-1:0] COEF_14 = ANCHO'(16'hFFFE);
    localparam logic [ANCHO-1:0] COEF_15 = ANCHO'(16'hFFFC);

    function automatic logic [ANCHO-1:0] coef_def(input int k);
        unique case (k)
            0:       coef_def = COEF_0;
            1:       coef_def = COEF_1;
            2:       coef_def = COEF_2;
            3:       coef_def = COEF_3;
            4:       coef_def = COEF_4;
            5:       coef_def = COEF_5;
            6:       coef_def = COEF_6;
            7:       coef_def = COEF_7;
            8:       coef_def = COEF_8;
            9:       coef_def = COEF_9;
            10:      coef_def = COEF_10;
            11:      coef_def = COEF_11;
            12:      coef_def = COEF_12;
            13:      coef_def = COEF_13;
            14:      coef_def = COEF_14;
            default: coef_def = COEF_15;
        endcase
    endfunction

endpackage

// File: rtl/fir_linea_retardo.sv
// TAPS-deep sample shift register with indexed read and synchronous clear.
module fir_linea_retardo #(
    parameter int ANCHO = 16,
    parameter int TAPS  = 4,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_desplaza,
    input  logic             i_clr,
    input  logic [ANCHO-1:0] i_dato,
    input  logic [IW-1:0]    i_idx,
    output logic [ANCHO-1:0] o_dato
);

    logic [ANCHO-1:0] r_d [TAPS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) r_d[k] <= '0;
        end else if (i_clr) begin
            for (int k = 0; k < TAPS; k++) r_d[k] <= '0;
        end else if (i_desplaza) begin
            r_d[0] <= i_dato;
            for (int k = 1; k < TAPS; k++) r_d[k] <= r_d[k-1];
        end
    end

    assign o_dato = r_d[i_idx];

endmodule

// File: rtl/fir_secuenciador_mac.sv
// Feeds an external multiply-add stage one tap per cycle and registers the filter output.
// FIR_COEF_WR_EN adds a writable coefficient file (coef_we/coef_dir/coef_dato).
module fir_secuenciador_mac
    import fir_secuenciador_mac_pkg::*;
#(
    parameter int ANCHO = fir_secuenciador_mac_pkg::ANCHO,
    parameter int TAPS  = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ANCHO-1:0] muestra,
    input  logic             muestra_valida,
    output logic             listo,
    output logic [ANCHO-1:0] mac_op1,
    output logic [ANCHO-1:0] mac_op2,
    output logic [ANCHO-1:0] mac_op3,
    input  logic [ANCHO-1:0] mac_resultado,
    input  logic             mac_sat,
`ifdef FIR_COEF_WR_EN
    input  logic             coef_we,
    input  logic [CNT_W-1:0] coef_dir,
    input  logic [ANCHO-1:0] coef_dato,
`endif
    output logic [ANCHO-1:0] salida,
    output logic             salida_valida,
    output logic             saturado
);

    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    estado_t          r_estado;
    estado_t          w_estado_sig;
    logic [CNT_W-1:0] r_cnt;
    logic [ANCHO-1:0] r_acum;
    logic             r_sticky;
    logic [ANCHO-1:0] r_salida;
    logic             r_salida_valida;
    logic             r_saturado;
    logic             w_acepta;
    logic             w_ultimo;
    logic [IW-1:0]    w_idx;
    logic [ANCHO-1:0] w_coef_sel;
    logic [ANCHO-1:0] w_dato_ret;

    assign w_acepta = (r_estado == REPOSO) && muestra_valida;
    assign w_ultimo = (r_cnt == CNT_W'(TAPS - 1));
    assign w_idx    = r_cnt[IW-1:0];

`ifdef FIR_COEF_WR_EN
    logic [ANCHO-1:0] r_coef [TAPS];

    // Only idle writes land, so a tap sequence never sees a coefficient change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
        end else if (r_estado == REPOSO && coef_we
                     && int'(coef_dir) < TAPS) begin
            r_coef[coef_dir[IW-1:0]] <= coef_dato;
        end
    end

    assign w_coef_sel = r_coef[w_idx];
`else
    logic [ANCHO-1:0] w_coef [TAPS];

    for (genvar k = 0; k < TAPS; k++) begin : g_coef
        assign w_coef[k] = coef_def(k);
    end

    assign w_coef_sel = w_coef[w_idx];
`endif

    fir_linea_retardo #(
        .ANCHO (ANCHO),
        .TAPS  (TAPS),
        .IW    (IW)
    ) u_linea (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_desplaza (w_acepta),
        .i_clr      (1'b0),
        .i_dato     (muestra),
        .i_idx      (w_idx),
        .o_dato     (w_dato_ret)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_estado <= REPOSO;
        else          r_estado <= w_estado_sig;
    end

    always_comb begin
        w_estado_sig = r_estado;
        listo        = 1'b0;
        mac_op1      = '0;
        mac_op2      = '0;
        mac_op3      = '0;
        unique case (r_estado)
            REPOSO: begin
                listo = 1'b1;
                if (muestra_valida) w_estado_sig = CALCULO;
            end
            CALCULO: begin
                mac_op1 = w_coef_sel;
                mac_op2 = w_dato_ret;
                mac_op3 = (r_cnt == '0) ? '0 : r_acum;
                if (w_ultimo) w_estado_sig = ENTREGA;
            end
            ENTREGA: w_estado_sig = REPOSO;
            default: w_estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt           <= '0;
            r_acum          <= '0;
            r_sticky        <= 1'b0;
            r_salida        <= '0;
            r_salida_valida <= 1'b0;
            r_saturado      <= 1'b0;
        end else begin
            r_salida_valida <= 1'b0;
            unique case (r_estado)
                REPOSO: begin
                    if (muestra_valida) begin
                        r_cnt    <= '0;
                        r_acum   <= '0;
                        r_sticky <= 1'b0;
                    end
                end
                CALCULO: begin
                    r_acum   <= mac_resultado;
                    r_sticky <= r_sticky | mac_sat;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                ENTREGA: begin
                    r_salida        <= r_acum;
                    r_saturado      <= r_sticky;
                    r_salida_valida <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign salida        = r_salida;
    assign salida_valida = r_salida_valida;
    assign saturado      = r_saturado;

endmodule

// File: tb/tb_fir_secuenciador_mac.sv
// Directed + random bench for fir_secuenciador_mac with a Q3.12 saturating MAC stand-in.
module tb_fir_secuenciador_mac;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] muestra;
    logic        muestra_valida;
    logic        listo;
    logic [15:0] mac_op1, mac_op2, mac_op3;
    logic [15:0] mac_resultado;
    logic        mac_sat;
    logic [15:0] salida;
    logic        salida_valida;
    logic        saturado;
`ifdef FIR_COEF_WR_EN
    logic        coef_we;
    logic [3:0]  coef_dir;
    logic [15:0] coef_dato;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] hist   [4];
    logic [15:0] coef_m [4];

    always #5 clk = ~clk;

    fir_secuenciador_mac #(.ANCHO(16), .TAPS(4), .CNT_W(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .muestra        (muestra),
        .muestra_valida (muestra_valida),
        .listo          (listo),
        .mac_op1        (mac_op1),
        .mac_op2        (mac_op2),
        .mac_op3        (mac_op3),
        .mac_resultado  (mac_resultado),
        .mac_sat        (mac_sat),
`ifdef FIR_COEF_WR_EN
        .coef_we        (coef_we),
        .coef_dir       (coef_dir),
        .coef_dato      (coef_dato),
`endif
        .salida         (salida),
        .salida_valida  (salida_valida),
        .saturado       (saturado)
    );

    // {sat, result} of trunc(a*b >> 12 + c) with saturation
    function automatic logic [16:0] mac_f(input logic [15:0] a, b, c);
        int p, t;
        p = (int'($signed(a)) * int'($signed(b))) >>> 12;
        t = p + int'($signed(c));
        if (t > 32767)       return {1'b1, 16'h7FFF};
        else if (t < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, t[15:0]};
    endfunction

    assign {mac_sat, mac_resultado} = mac_f(mac_op1, mac_op2, mac_op3);

    function automatic logic [16:0] filtro_ref();
        logic [15:0] acc;
        logic        s;
        logic [16:0] r;
        acc = 16'h0;
        s   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r   = mac_f(coef_m[k], hist[k], acc);
            acc = r[15:0];
            s   = s | r[16];
        end
        return {s, acc};
    endfunction

    task automatic push_hist(input logic [15:0] x);
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample: wait for listo, handshake, then expect the result 5 edges later.
    task automatic ciclo(input logic [15:0] x, input string tag);
        int n;
        logic [16:0] e;
        @(negedge clk);
        muestra = x;
        muestra_valida = 1'b1;
        n = 0;
        while (listo !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_listo"}, 32'(listo), 32'd1);
        @(posedge clk);
        push_hist(x);
        e = filtro_ref();
        #1 muestra_valida = 1'b0;
        chk({tag, "_busy"}, 32'(listo), 32'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (salida_valida !== 1'b1 && n < 12);
        chk({tag, "_lat"}, 32'(n), 32'd5);
        chk({tag, "_y"}, 32'(salida), 32'(e[15:0]));
        chk({tag, "_sat"}, 32'(saturado), 32'(e[16]));
    endtask

`ifdef FIR_COEF_WR_EN
    task automatic escribe(input logic [3:0] dir, input logic [15:0] v, input bit aplica);
        @(negedge clk);
        coef_we = 1'b1;
        coef_dir = dir;
        coef_dato = v;
        @(posedge clk);
        if (aplica && dir < 4) coef_m[dir[1:0]] = v;
        #1 coef_we = 1'b0;
    endtask
`endif

    initial begin
        int hs, last, pulses;
        logic [16:0] q[$];
        logic [16:0] e;
        bit hs_now;

        reset_n = 1'b0;
        muestra = '0;
        muestra_valida = 1'b0;
`ifdef FIR_COEF_WR_EN
        coef_we = 1'b0;
        coef_dir = '0;
        coef_dato = '0;
        for (int k = 0; k < 4; k++) coef_m[k] = 16'h0;
`else
        coef_m[0] = 16'h1000;
        coef_m[1] = 16'h0800;
        coef_m[2] = 16'h0400;
        coef_m[3] = 16'h0200;
`endif
        for (int k = 0; k < 4; k++) hist[k] = 16'h0;

        repeat (3) @(negedge clk);
        chk("rst_salida", 32'(salida), 32'd0);
        chk("rst_valida", 32'(salida_valida), 32'd0);
        chk("rst_listo", 32'(listo), 32'd1);
        chk("rst_op1", 32'(mac_op1), 32'd0);
        chk("rst_op2", 32'(mac_op2), 32'd0);
        chk("rst_op3", 32'(mac_op3), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_listo", 32'(listo), 32'd1);
        chk("idle_valida", 32'(salida_valida), 32'd0);

`ifdef FIR_COEF_WR_EN
        escribe(4'd0, 16'h1000, 1'b1);
        escribe(4'd1, 16'h0800, 1'b1);
        escribe(4'd2, 16'h0400, 1'b1);
        escribe(4'd3, 16'h0200, 1'b1);
        escribe(4'd7, 16'h7777, 1'b0);
`endif

        ciclo(16'h1000, "imp0");
        chk("imp0_const", 32'(salida), 32'h1000);
        ciclo(16'h0000, "imp1");
        ciclo(16'h0000, "imp2");
        ciclo(16'h0000, "imp3");
        chk("imp3_const", 32'(salida), 32'h0200);

        for (int i = 0; i < 4; i++) ciclo(16'h7FFF, "satin");
        chk("sat_flag", 32'(saturado), 32'd1);
        for (int i = 0; i < 4; i++) ciclo(16'h0000, "satout");
        chk("sat_clear", 32'(saturado), 32'd0);

        for (int i = 0; i < 8; i++) ciclo(16'($urandom_range(0, 16'hFFFF)), "rnd");

        // Backpressure: valid held high, one acceptance every 6 cycles.
        @(posedge clk);
        muestra = 16'h0300;
        hs = 0;
        last = -1;
        #1 muestra_valida = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (salida_valida === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                chk("bp_y", 32'(salida), 32'(e[15:0]));
            end
            hs_now = listo;
            @(posedge clk);
            if (hs_now) begin
                if (last >= 0) chk("bp_gap", 32'(c - last), 32'd6);
                last = c;
                hs++;
                push_hist(muestra);
                q.push_back(filtro_ref());
            end
        end
        #1 muestra_valida = 1'b0;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge clk);
            if (salida_valida === 1'b1) begin
                e = q.pop_front();
                chk("bp_y", 32'(salida), 32'(e[15:0]));
            end
        end
        chk("bp_hs", 32'(hs), 32'd6);
        chk("bp_drain", 32'(q.size()), 32'd0);

        // Reset at tap 2 aborts the sample and clears the history.
        @(negedge clk);
        muestra = 16'h4000;
        muestra_valida = 1'b1;
        @(posedge clk);
        #1 muestra_valida = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_listo", 32'(listo), 32'd1);
        chk("mr_op1", 32'(mac_op1), 32'd0);
        chk("mr_salida", 32'(salida), 32'd0);
        for (int k = 0; k < 4; k++) hist[k] = 16'h0;
`ifdef FIR_COEF_WR_EN
        for (int k = 0; k < 4; k++) coef_m[k] = 16'h0;
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (salida_valida === 1'b1) pulses++;
        end
        chk("mr_nopulse", 32'(pulses), 32'd0);

`ifdef FIR_COEF_WR_EN
        escribe(4'd0, 16'h1000, 1'b1);
        @(negedge clk);
        muestra = 16'h1000;
        muestra_valida = 1'b1;
        @(posedge clk);
        push_hist(16'h1000);
        #1 muestra_valida = 1'b0;
        escribe(4'd1, 16'h1000, 1'b0);
        repeat (8) @(posedge clk);
        ciclo(16'h0000, "wr_drop");
        chk("wr_drop_c", 32'(salida), 32'h0000);
        escribe(4'd1, 16'h1000, 1'b1);
        ciclo(16'h1000, "wr_imp0");
        ciclo(16'h0000, "wr_imp1");
        chk("wr_tap1", 32'(salida), 32'h1000);
`else
        ciclo(16'h1000, "mr_imp0");
        chk("mr_imp0_c", 32'(salida), 32'h1000);
        ciclo(16'h0000, "mr_imp1");
        chk("mr_imp1_c", 32'(salida), 32'h0800);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
